// File: rtl/pipeline_types_pkg.sv
// rtl/pipeline_types_pkg.sv - shared commit-stage types and helpers
package pipeline_types;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        reg_we;
        logic [4:0]  reg_addr;
        logic [31:0] reg_data;
        logic        excp;
        logic [5:0]  ecode;
        logic        ertn;
        logic        idle;
    } commit_slot_t;

    typedef enum logic {
        RUN  = 1'b0,
        IDLE = 1'b1
    } ctrl_state_e;

    localparam logic [5:0]  ECODE_INT  = 6'h0;
    localparam logic [31:0] INSN_BYTES = 32'd4;

    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + INSN_BYTES;
    endfunction

endpackage

// File: rtl/pause_mask_gen.sv
// rtl/pause_mask_gen.sv - prefix-OR stall propagation with flush override
module pause_mask_gen #(
    parameter int WIDTH = 7
) (
    input  logic [WIDTH-1:0] pause_req,
    input  logic [WIDTH-1:0] flush,
    output logic [WIDTH-1:0] pause
);

    logic acc;

    // A stall at stage i also stalls every younger stage below it.
    always_comb begin
        pause = '0;
        acc   = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc      = acc | pause_req[i];
            pause[i] = acc & ~flush[i];
        end
    end

endmodule

// File: rtl/commit_ctrl_n.sv
// rtl/commit_ctrl_n.sv - N-wide commit stage with exception/ertn/idle resolution and pipeline control
module commit_ctrl_n
    import pipeline_types::*;
#(
    parameter int ISSUE_WIDTH = 2,
    parameter int PIPE_WIDTH  = 7,
    parameter int EX_STAGE    = 5,
    parameter int CNT_WIDTH   = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ISSUE_WIDTH-1:0]        slot_valid,
    input  logic [ISSUE_WIDTH-1:0][31:0]  slot_pc,
    input  logic [ISSUE_WIDTH-1:0]        slot_reg_we,
    input  logic [ISSUE_WIDTH-1:0][4:0]   slot_reg_addr,
    input  logic [ISSUE_WIDTH-1:0][31:0]  slot_reg_data,
    input  logic [ISSUE_WIDTH-1:0]        slot_excp,
    input  logic [ISSUE_WIDTH-1:0][5:0]   slot_ecode,
    input  logic [ISSUE_WIDTH-1:0]        slot_ertn,
    input  logic [ISSUE_WIDTH-1:0]        slot_idle,
    input  logic [PIPE_WIDTH-1:0]         pause_req,
    input  logic                          branch_flush,
    input  logic [31:0]                   branch_target,
    input  logic                          int_pending,
    input  logic [31:0]                   csr_eentry,
    input  logic [31:0]                   csr_era,
    output logic [ISSUE_WIDTH-1:0]        reg_write_en,
    output logic [ISSUE_WIDTH-1:0][4:0]   reg_write_addr,
    output logic [ISSUE_WIDTH-1:0][31:0]  reg_write_data,
    output logic                          excp_commit,
    output logic [5:0]                    excp_ecode,
    output logic [31:0]                   excp_pc,
    output logic                          ertn_commit,
    output logic [PIPE_WIDTH-1:0]         flush,
    output logic [PIPE_WIDTH-1:0]         pause,
    output logic [31:0]                   new_pc,
    output logic                          idle_o,
    output logic [CNT_WIDTH-1:0]          commit_cnt
);

    localparam logic [PIPE_WIDTH-1:0] BR_MASK = PIPE_WIDTH'((1 << EX_STAGE) - 1);

    commit_slot_t              slot_q [ISSUE_WIDTH];
    ctrl_state_e               state_q, state_d;
    logic [31:0]               idle_ret_q;
    logic [CNT_WIDTH-1:0]      cnt_q;

    logic                      hold, any_valid, int_take, run_active;
    logic [ISSUE_WIDTH-1:0]    commit_mask;
    logic [CNT_WIDTH-1:0]      commit_num;
    logic                      found, take_excp, take_ertn, take_idle;
    logic [31:0]               sel_pc;
    logic [5:0]                sel_ecode;

    logic [PIPE_WIDTH-1:0]     flush_int, pause_src, pause_int;
    logic [31:0]               new_pc_int, excp_pc_int;
    logic                      excp_int;
    logic [5:0]                excp_ecode_int;

    assign hold = pause_req[PIPE_WIDTH-1];

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            any_valid = any_valid | slot_q[i].valid;
        end
    end

    assign int_take   = (state_q == RUN) & ~hold & int_pending & any_valid;
    assign run_active = (state_q == RUN) & ~hold & ~int_take;

    // Oldest special slot wins; everything younger than it is dropped.
    always_comb begin
        commit_mask = '0;
        commit_num  = '0;
        found       = 1'b0;
        take_excp   = 1'b0;
        take_ertn   = 1'b0;
        take_idle   = 1'b0;
        sel_pc      = '0;
        sel_ecode   = '0;
        if (run_active) begin
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                if (slot_q[i].valid && !found) begin
                    if (slot_q[i].excp) begin
                        found     = 1'b1;
                        take_excp = 1'b1;
                        sel_pc    = slot_q[i].pc;
                        sel_ecode = slot_q[i].ecode;
                    end else begin
                        commit_mask[i] = 1'b1;
                        commit_num     = commit_num + CNT_WIDTH'(1);
                        if (slot_q[i].ertn) begin
                            found     = 1'b1;
                            take_ertn = 1'b1;
                        end else if (slot_q[i].idle) begin
                            found     = 1'b1;
                            take_idle = 1'b1;
                            sel_pc    = slot_q[i].pc;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        flush_int      = '0;
        new_pc_int     = '0;
        excp_int       = 1'b0;
        excp_ecode_int = '0;
        excp_pc_int    = '0;
        pause_src      = pause_req;
        if (state_q == IDLE) begin
            if (int_pending) begin
                state_d        = RUN;
                excp_int       = 1'b1;
                excp_ecode_int = ECODE_INT;
                excp_pc_int    = idle_ret_q;
                flush_int      = '1;
                new_pc_int     = csr_eentry;
            end else begin
                pause_src = '1;
            end
        end else if (int_take) begin
            excp_int       = 1'b1;
            excp_ecode_int = ECODE_INT;
            excp_pc_int    = slot_q[0].pc;
            flush_int      = '1;
            new_pc_int     = csr_eentry;
        end else if (take_excp) begin
            excp_int       = 1'b1;
            excp_ecode_int = sel_ecode;
            excp_pc_int    = sel_pc;
            flush_int      = '1;
            new_pc_int     = csr_eentry;
        end else if (take_ertn) begin
            flush_int  = '1;
            new_pc_int = csr_era;
        end else if (take_idle) begin
            state_d    = IDLE;
            flush_int  = '1;
            new_pc_int = next_pc(sel_pc);
        end else if (branch_flush) begin
            flush_int  = BR_MASK;
            new_pc_int = branch_target;
        end
    end

    pause_mask_gen #(
        .WIDTH(PIPE_WIDTH)
    ) u_pause_mask_gen (
        .pause_req(pause_src),
        .flush    (flush_int),
        .pause    (pause_int)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                slot_q[i] <= '0;
            end
        end else if (flush_int[PIPE_WIDTH-1]) begin
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                slot_q[i].valid <= 1'b0;
            end
        end else if (!hold) begin
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                slot_q[i] <= '{valid:    slot_valid[i],
                               pc:       slot_pc[i],
                               reg_we:   slot_reg_we[i],
                               reg_addr: slot_reg_addr[i],
                               reg_data: slot_reg_data[i],
                               excp:     slot_excp[i],
                               ecode:    slot_ecode[i],
                               ertn:     slot_ertn[i],
                               idle:     slot_idle[i]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            idle_ret_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_q + commit_num;
            if (take_idle) begin
                idle_ret_q <= next_pc(sel_pc);
            end
        end
    end

    always_comb begin
        reg_write_en   = '0;
        reg_write_addr = '0;
        reg_write_data = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (!rst && commit_mask[i] && slot_q[i].reg_we) begin
                reg_write_en[i]   = 1'b1;
                reg_write_addr[i] = slot_q[i].reg_addr;
                reg_write_data[i] = slot_q[i].reg_data;
            end
        end
    end

    assign excp_commit = excp_int & ~rst;
    assign excp_ecode  = rst ? '0 : excp_ecode_int;
    assign excp_pc     = rst ? '0 : excp_pc_int;
    assign ertn_commit = take_ertn & ~rst;
    assign flush       = rst ? '0 : flush_int;
    assign pause       = rst ? '0 : pause_int;
    assign new_pc      = rst ? '0 : new_pc_int;
    assign idle_o      = (state_q == IDLE) & ~rst;
    assign commit_cnt  = cnt_q;

endmodule

// File: tb/tb_commit_ctrl_n.sv
// tb/tb_commit_ctrl_n.sv - directed and randomized checks of commit_ctrl_n against a behavioural model
module tb_commit_ctrl_n;

    localparam int IW = 2;
    localparam int PW = 7;
    localparam int EX = 5;
    localparam int CW = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst;
    logic [IW-1:0]         slot_valid, slot_reg_we, slot_excp, slot_ertn, slot_idle;
    logic [IW-1:0][31:0]   slot_pc, slot_reg_data;
    logic [IW-1:0][4:0]    slot_reg_addr;
    logic [IW-1:0][5:0]    slot_ecode;
    logic [PW-1:0]         pause_req;
    logic                  branch_flush, int_pending;
    logic [31:0]           branch_target, csr_eentry, csr_era;

    logic [IW-1:0]         reg_write_en;
    logic [IW-1:0][4:0]    reg_write_addr;
    logic [IW-1:0][31:0]   reg_write_data;
    logic                  excp_commit, ertn_commit, idle_o;
    logic [5:0]            excp_ecode;
    logic [31:0]           excp_pc, new_pc;
    logic [PW-1:0]         flush, pause;
    logic [CW-1:0]         commit_cnt;

    commit_ctrl_n #(
        .ISSUE_WIDTH(IW), .PIPE_WIDTH(PW), .EX_STAGE(EX), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .slot_valid(slot_valid), .slot_pc(slot_pc), .slot_reg_we(slot_reg_we),
        .slot_reg_addr(slot_reg_addr), .slot_reg_data(slot_reg_data),
        .slot_excp(slot_excp), .slot_ecode(slot_ecode), .slot_ertn(slot_ertn), .slot_idle(slot_idle),
        .pause_req(pause_req), .branch_flush(branch_flush), .branch_target(branch_target),
        .int_pending(int_pending), .csr_eentry(csr_eentry), .csr_era(csr_era),
        .reg_write_en(reg_write_en), .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data),
        .excp_commit(excp_commit), .excp_ecode(excp_ecode), .excp_pc(excp_pc),
        .ertn_commit(ertn_commit), .flush(flush), .pause(pause), .new_pc(new_pc),
        .idle_o(idle_o), .commit_cnt(commit_cnt)
    );

    typedef struct {
        logic v; logic [31:0] pc; logic we; logic [4:0] a; logic [31:0] d;
        logic ex; logic [5:0] ec; logic er; logic id;
    } mslot_t;

    mslot_t        m_slot [IW];
    logic          m_idle;
    logic [31:0]   m_ret;
    logic [63:0]   m_cnt;

    logic [IW-1:0]       e_we;
    logic [IW-1:0][4:0]  e_addr;
    logic [IW-1:0][31:0] e_data;
    logic                e_excp, e_ertn;
    logic [5:0]          e_ec;
    logic [31:0]         e_epc, e_npc, g_ret;
    logic [PW-1:0]       e_flush, e_pause;
    int                  n_commit;
    logic                wake, goto_idle;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        slot_valid = '0; slot_reg_we = '0; slot_excp = '0; slot_ertn = '0; slot_idle = '0;
        slot_pc = '0; slot_reg_data = '0; slot_reg_addr = '0; slot_ecode = '0;
        pause_req = '0; branch_flush = 1'b0; branch_target = '0; int_pending = 1'b0;
    endtask

    task automatic set_slot(input int i, input logic [31:0] pc, input logic we, input logic [4:0] a,
                            input logic [31:0] d, input logic ex, input logic [5:0] ec,
                            input logic er, input logic id);
        slot_valid[i] = 1'b1; slot_pc[i] = pc; slot_reg_we[i] = we; slot_reg_addr[i] = a;
        slot_reg_data[i] = d; slot_excp[i] = ex; slot_ecode[i] = ec; slot_ertn[i] = er; slot_idle[i] = id;
    endtask

    // Expected outputs for the current cycle, derived from the model's view of the retiring bundle.
    task automatic eval_cycle();
        logic held, any_v, done;
        @(negedge clk); #1;
        e_we = '0; e_addr = '0; e_data = '0; e_excp = 1'b0; e_ertn = 1'b0; e_ec = '0;
        e_epc = '0; e_npc = '0; e_flush = '0; e_pause = '0; g_ret = '0;
        n_commit = 0; wake = 1'b0; goto_idle = 1'b0;
        held = pause_req[PW-1];
        if (!rst) begin
            if (m_idle) begin
                if (int_pending) begin
                    wake = 1'b1; e_excp = 1'b1; e_epc = m_ret; e_flush = '1; e_npc = csr_eentry;
                end
            end else begin
                any_v = 1'b0;
                for (int i = 0; i < IW; i++) any_v = any_v | m_slot[i].v;
                if (!held && any_v && int_pending) begin
                    e_excp = 1'b1; e_epc = m_slot[0].pc; e_flush = '1; e_npc = csr_eentry;
                end else begin
                    done = 1'b0;
                    for (int i = 0; i < IW; i++) begin
                        if (!held && !done && m_slot[i].v) begin
                            if (m_slot[i].ex) begin
                                e_excp = 1'b1; e_ec = m_slot[i].ec; e_epc = m_slot[i].pc; done = 1'b1;
                            end else begin
                                n_commit++;
                                if (m_slot[i].we) begin
                                    e_we[i] = 1'b1; e_addr[i] = m_slot[i].a; e_data[i] = m_slot[i].d;
                                end
                                if (m_slot[i].er) begin
                                    e_ertn = 1'b1; done = 1'b1;
                                end else if (m_slot[i].id) begin
                                    goto_idle = 1'b1; g_ret = m_slot[i].pc + 32'd4; done = 1'b1;
                                end
                            end
                        end
                    end
                    if (e_excp) begin
                        e_flush = '1; e_npc = csr_eentry;
                    end else if (e_ertn) begin
                        e_flush = '1; e_npc = csr_era;
                    end else if (goto_idle) begin
                        e_flush = '1; e_npc = g_ret;
                    end else if (branch_flush) begin
                        e_flush = PW'((1 << EX) - 1); e_npc = branch_target;
                    end
                end
            end
            if (m_idle && !wake) e_pause = '1;
            else for (int i = 0; i < PW; i++) e_pause[i] = ((pause_req >> i) != '0) && !e_flush[i];
        end
        chk("reg_write_en", 64'(reg_write_en), 64'(e_we));
        for (int i = 0; i < IW; i++) begin
            chk("reg_write_addr", 64'(reg_write_addr[i]), 64'(e_addr[i]));
            chk("reg_write_data", 64'(reg_write_data[i]), 64'(e_data[i]));
        end
        chk("excp_commit", 64'(excp_commit), 64'(e_excp));
        chk("excp_ecode", 64'(excp_ecode), 64'(e_ec));
        chk("excp_pc", 64'(excp_pc), 64'(e_epc));
        chk("ertn_commit", 64'(ertn_commit), 64'(e_ertn));
        chk("flush", 64'(flush), 64'(e_flush));
        chk("pause", 64'(pause), 64'(e_pause));
        chk("new_pc", 64'(new_pc), 64'(e_npc));
        chk("idle_o", 64'(idle_o), 64'((!rst) && m_idle));
        chk("commit_cnt", commit_cnt, m_cnt);
    endtask

    task automatic advance();
        @(posedge clk); #1;
        if (rst) begin
            for (int i = 0; i < IW; i++) m_slot[i] = '{default: '0};
            m_idle = 1'b0; m_ret = '0; m_cnt = '0;
        end else begin
            m_cnt = m_cnt + 64'(n_commit);
            if (wake) m_idle = 1'b0;
            else if (goto_idle) begin m_idle = 1'b1; m_ret = g_ret; end
            if (e_flush[PW-1]) begin
                for (int i = 0; i < IW; i++) m_slot[i].v = 1'b0;
            end else if (!pause_req[PW-1]) begin
                for (int i = 0; i < IW; i++) begin
                    m_slot[i].v = slot_valid[i]; m_slot[i].pc = slot_pc[i]; m_slot[i].we = slot_reg_we[i];
                    m_slot[i].a = slot_reg_addr[i]; m_slot[i].d = slot_reg_data[i];
                    m_slot[i].ex = slot_excp[i]; m_slot[i].ec = slot_ecode[i];
                    m_slot[i].er = slot_ertn[i]; m_slot[i].id = slot_idle[i];
                end
            end
        end
    endtask

    task automatic step();
        eval_cycle();
        advance();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        csr_eentry = 32'h1C00_8000;
        csr_era    = 32'h1C00_4000;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < IW; i++) m_slot[i] = '{default: '0};
        m_idle = 1'b0; m_ret = '0; m_cnt = '0;
        rst = 1'b0;

        eval_cycle();
        chk("reset_cnt", commit_cnt, 64'd0);
        chk("reset_flush", 64'(flush), 64'd0);
        advance();

        set_slot(0, 32'h1C00_0000, 1'b1, 5'd3, 32'h11, 1'b0, 6'h0, 1'b0, 1'b0);
        set_slot(1, 32'h1C00_0004, 1'b1, 5'd4, 32'h22, 1'b0, 6'h0, 1'b0, 1'b0);
        step();
        clear_inputs();
        eval_cycle();
        chk("t1_we", 64'(reg_write_en), 64'h3);
        chk("t1_data1", 64'(reg_write_data[1]), 64'h22);
        advance();
        eval_cycle();
        chk("t1_cnt", commit_cnt, 64'd2);
        advance();

        set_slot(0, 32'h1C00_8000, 1'b1, 5'd5, 32'h55, 1'b0, 6'h0, 1'b0, 1'b0);
        set_slot(1, 32'h1C00_8004, 1'b1, 5'd6, 32'h66, 1'b1, 6'h0B, 1'b0, 1'b0);
        step();
        clear_inputs();
        eval_cycle();
        chk("t2_we", 64'(reg_write_en), 64'h1);
        chk("t2_excp_pc", 64'(excp_pc), 64'h1C00_8004);
        chk("t2_flush", 64'(flush), 64'h7F);
        advance();

        pause_req = 7'b0001000;
        eval_cycle();
        chk("t3_pause", 64'(pause), 64'b0001111);
        advance();
        pause_req = '0;
        set_slot(0, 32'h1C00_1000, 1'b1, 5'd7, 32'hA5, 1'b0, 6'h0, 1'b0, 1'b0);
        set_slot(1, 32'h1C00_1004, 1'b1, 5'd8, 32'h5A, 1'b0, 6'h0, 1'b0, 1'b0);
        step();
        for (int k = 0; k < 3; k++) begin
            pause_req = 7'b1000000;
            set_slot(0, 32'h1C00_2000, 1'b1, 5'd9, 32'hDEAD, 1'b0, 6'h0, 1'b0, 1'b0);
            eval_cycle();
            chk("t3_hold_we", 64'(reg_write_en), 64'h0);
            advance();
        end
        clear_inputs();
        eval_cycle();
        chk("t3_release_data0", 64'(reg_write_data[0]), 64'hA5);
        advance();
        eval_cycle();
        chk("t3_cnt", commit_cnt, 64'd5);
        advance();

        branch_flush = 1'b1; branch_target = 32'h1C00_0100;
        eval_cycle();
        chk("t4_br_flush", 64'(flush), 64'b0011111);
        chk("t4_br_pc", 64'(new_pc), 64'h1C00_0100);
        advance();
        clear_inputs();
        set_slot(0, 32'h1C00_0300, 1'b0, 5'd0, 32'h0, 1'b0, 6'h0, 1'b1, 1'b0);
        step();
        clear_inputs();
        branch_flush = 1'b1; branch_target = 32'h1C00_0100;
        eval_cycle();
        chk("t4_ertn_pc", 64'(new_pc), 64'h1C00_4000);
        advance();
        clear_inputs();

        set_slot(0, 32'h1C00_0200, 1'b0, 5'd0, 32'h0, 1'b0, 6'h0, 1'b0, 1'b1);
        step();
        clear_inputs();
        eval_cycle();
        chk("t5_idle_pc", 64'(new_pc), 64'h1C00_0204);
        advance();
        for (int k = 0; k < 5; k++) begin
            eval_cycle();
            chk("t5_idle_pause", 64'(pause), 64'h7F);
            advance();
        end
        int_pending = 1'b1;
        eval_cycle();
        chk("t5_wake_pc", 64'(excp_pc), 64'h1C00_0204);
        chk("t5_wake_ecode", 64'(excp_ecode), 64'h0);
        advance();
        int_pending = 1'b0;
        eval_cycle();
        chk("t5_idle_o", 64'(idle_o), 64'h0);
        advance();

        set_slot(0, 32'h1C00_0400, 1'b0, 5'd0, 32'h0, 1'b0, 6'h0, 1'b0, 1'b1);
        step();
        clear_inputs();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        eval_cycle();
        chk("t6_idle_rst_cnt", commit_cnt, 64'd0);
        chk("t6_idle_rst_pause", 64'(pause), 64'h0);
        advance();
        set_slot(0, 32'h1C00_0500, 1'b1, 5'd10, 32'h77, 1'b0, 6'h0, 1'b0, 1'b0);
        step();
        clear_inputs();
        pause_req = 7'b1000000;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_inputs();
        eval_cycle();
        chk("t6_hold_rst_we", 64'(reg_write_en), 64'h0);
        advance();

        for (int c = 0; c < 300; c++) begin
            rst           = ($urandom_range(0, 99) == 0);
            pause_req     = PW'($urandom & $urandom & $urandom);
            branch_flush  = ($urandom_range(0, 7) == 0);
            branch_target = $urandom & 32'hFFFF_FFFC;
            int_pending   = ($urandom_range(0, 15) == 0);
            csr_eentry    = $urandom & 32'hFFFF_FFFC;
            csr_era       = $urandom & 32'hFFFF_FFFC;
            for (int i = 0; i < IW; i++) begin
                slot_valid[i]    = 1'($urandom_range(0, 1));
                slot_pc[i]       = $urandom & 32'hFFFF_FFFC;
                slot_reg_we[i]   = 1'($urandom_range(0, 1));
                slot_reg_addr[i] = 5'($urandom);
                slot_reg_data[i] = $urandom;
                slot_excp[i]     = ($urandom_range(0, 11) == 0);
                slot_ecode[i]    = 6'($urandom_range(1, 63));
                slot_ertn[i]     = ($urandom_range(0, 11) == 0);
                slot_idle[i]     = ($urandom_range(0, 11) == 0);
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
